// File: rtl/mux_rr.sv
// mux_rr: N-channel registered mux with fixed-select or round-robin grant and valid/ready handshakes.
// Optional out_parity port (even parity of out_data) when MUX_RR_PARITY_EN is defined.
module mux_rr #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = (N <= 2) ? 1 : $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [SW-1:0]    sel,
    input  logic             mode,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_ch,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MUX_RR_PARITY_EN
    ,
    output logic             out_parity
`endif
);
    localparam int SW1 = SW + 1;

    logic [SW-1:0]  ptr;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic           fix_hit, rr_hit, hit, accept, xfer;
    logic [SW-1:0]  fix_g, rr_g, g;
    logic [SW1-1:0] rr_sum;
    logic [W-1:0]   g_data;

    // rotate valids so that bit 0 is the channel at ptr; the first set bit is the rr winner
    assign dbl = {in_valid, in_valid} >> ptr;
    assign rot = dbl[N-1:0];

    always_comb begin
        fix_hit = 1'b0;
        fix_g   = '0;
        rr_hit  = 1'b0;
        rr_sum  = '0;
        for (int i = 0; i < N; i++) begin
            if (in_valid[i] && sel == SW'(i)) begin
                fix_hit = 1'b1;
                fix_g   = SW'(i);
            end
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                rr_hit = 1'b1;
                rr_sum = {1'b0, ptr} + SW1'(k);
            end
        end
        rr_g = (rr_sum >= SW1'(N)) ? SW'(rr_sum - SW1'(N)) : SW'(rr_sum);
    end

    assign hit    = mode ? rr_hit : fix_hit;
    assign g      = mode ? rr_g : fix_g;
    assign accept = !out_valid || out_ready;
    assign xfer   = hit && accept;

    always_comb begin
        g_data = '0;
        for (int i = 0; i < N; i++) begin
            if (g == SW'(i)) g_data = in_data[i*W +: W];
        end
    end

    assign in_ready = (xfer && !reset) ? (N'(1) << g) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else begin
            if (accept) out_valid <= hit;
            if (xfer) begin
                out_data <= g_data;
                out_ch   <= g;
            end
            if (xfer && mode) ptr <= (g == SW'(N - 1)) ? '0 : g + SW'(1);
        end
    end

`ifdef MUX_RR_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) out_parity <= 1'b0;
        else if (xfer) out_parity <= ^g_data;
    end
`endif

endmodule

// File: tb/tb_mux_rr.sv
// tb_mux_rr: vector table, directed corner sequences and a randomized run against a reference model.
module tb_mux_rr;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [1:0]     sel;
    logic           mode;
    logic [W-1:0]   out_data;
    logic [1:0]     out_ch;
    logic           out_valid;
    logic           out_ready;
`ifdef MUX_RR_PARITY_EN
    logic           out_parity;
`endif

    int total = 0;
    int bad = 0;

    mux_rr #(.N(N), .W(W)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_RR_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] v;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] ch;
        logic [7:0] d;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // reference model state
    int m_ptr, m_ch, g, exp_rdy;
    logic m_ov;
    logic [7:0] m_data;
    logic acc;

    initial begin
        reset = 1'b1; in_data = '0; in_valid = '0; sel = '0; mode = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_ov", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_ready", in_ready, 0);
        reset = 1'b0;

        tbl[0] = '{2'd2, 4'b1111, 4'b0100, 1'b1, 2'd2, 8'hA5};
        tbl[1] = '{2'd2, 4'b1011, 4'b0000, 1'b0, 2'd2, 8'hA5};
        tbl[2] = '{2'd0, 4'b0001, 4'b0001, 1'b1, 2'd0, 8'h4B};
        tbl[3] = '{2'd3, 4'b1000, 4'b1000, 1'b1, 2'd3, 8'h3D};
        tbl[4] = '{2'd1, 4'b1101, 4'b0000, 1'b0, 2'd3, 8'h3D};
        mode = 1'b0; out_ready = 1'b1; in_data = {8'h3D, 8'hA5, 8'h12, 8'h4B};
        for (int i = 0; i < 5; i++) begin
            sel = tbl[i].sel; in_valid = tbl[i].v;
            #1 chk("tbl_ready", in_ready, tbl[i].rdy);
            tick();
            chk("tbl_ov", out_valid, tbl[i].ov);
            chk("tbl_ch", out_ch, tbl[i].ch);
            chk("tbl_data", out_data, tbl[i].d);
        end

        do_reset();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_ch", out_ch, k % 4);
            chk("rr_ov", out_valid, 1);
        end

        do_reset();
        mode = 1'b1; in_valid = 4'b0010;
        tick(); chk("wrap_ch1", out_ch, 1);
        in_valid = 4'b0100;
        tick(); chk("wrap_ch2", out_ch, 2);
        in_valid = 4'b0011;
        #1 chk("wrap_ready", in_ready, 4'b0001);
        tick(); chk("wrap_ch0", out_ch, 0);
        tick(); chk("wrap_ch1b", out_ch, 1);

        do_reset();
        mode = 1'b0; sel = 2'd1; in_data = {8'h3D, 8'hA5, 8'h3C, 8'h4B}; in_valid = 4'b0010; out_ready = 1'b1;
        tick(); chk("bp_load", out_data, 8'h3C);
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_ready", in_ready, 0);
            tick();
            chk("bp_data", out_data, 8'h3C);
            chk("bp_ov", out_valid, 1);
            chk("bp_ch", out_ch, 1);
        end
        out_ready = 1'b1;
        #1 chk("bp_rel_ready", in_ready, 4'b0001);
        tick();
        chk("bp_rel_data", out_data, 8'h4B);
        chk("bp_rel_ch", out_ch, 0);
        chk("bp_rel_ov", out_valid, 1);

        out_ready = 1'b0;
        tick();
        reset = 1'b1;
        #1 chk("mr_ready", in_ready, 0);
        tick();
        chk("mr_ov", out_valid, 0);
        chk("mr_data", out_data, 0);
        chk("mr_ch", out_ch, 0);
        reset = 1'b0; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        tick(); chk("mr_restart", out_ch, 0);

`ifdef MUX_RR_PARITY_EN
        do_reset();
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
        in_data = {24'h0, 8'h07};
        tick(); chk("par_07", out_parity, 1);
        in_data = {24'h0, 8'h03};
        tick(); chk("par_03", out_parity, 0);
`endif

        do_reset();
        m_ptr = 0; m_ch = 0; m_ov = 1'b0; m_data = '0;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            mode = 1'($urandom_range(0, 1));
            sel = 2'($urandom_range(0, 3));
            in_valid = 4'($urandom);
            in_data = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            g = -1;
            if (mode) begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end else if (in_valid[sel]) g = sel;
            acc = !m_ov || out_ready;
            exp_rdy = (!reset && acc && g >= 0) ? (1 << g) : 0;
            #1 chk("rnd_ready", in_ready, exp_rdy);
            tick();
            if (reset) begin
                m_ptr = 0; m_ch = 0; m_ov = 1'b0; m_data = '0;
            end else if (acc) begin
                m_ov = (g >= 0);
                if (g >= 0) begin
                    m_data = in_data[g*W +: W];
                    m_ch = g;
                    if (mode) m_ptr = (g + 1) % N;
                end
            end
            chk("rnd_ov", out_valid, m_ov);
            chk("rnd_data", out_data, m_data);
            chk("rnd_ch", out_ch, m_ch);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
